// File: rtl/lsu_mem_stage_if.sv
// Request/response handshake bundle between the pipeline memory stage and the LSU.
// master = pipeline side, slave = load/store unit.
interface lsu_mem_stage_if #(
    parameter int BYTE_ADDR_W = 17
);
    logic                   req_valid;
    logic                   req_ready;
    logic                   req_write;
    logic                   req_size;
    logic                   req_signed;
    logic [BYTE_ADDR_W-1:0] req_addr;
    logic [15:0]            req_wdata;
    logic                   resp_valid;
    logic                   resp_ready;
    logic [15:0]            resp_data;
    logic                   resp_err;

    modport master (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_data, resp_err
    );
endinterface

// File: rtl/lsu_mem_stage.sv
// Load/store unit: turns byte-addressed load/store requests into accesses on a
// 16-bit word memory; byte stores are done as read-modify-write.
module lsu_mem_stage #(
    parameter int BYTE_ADDR_W = 17
) (
    input  logic                 clk,
    input  logic                 reset,
    lsu_mem_stage_if.slave       bus,
    output logic [15:0]          mem_address,
    output logic                 mem_write_enable,
    output logic                 mem_read_enable,
    output logic [15:0]          mem_write_data,
    input  logic [15:0]          mem_read_data
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EXEC  = 2'd1,
        ST_MERGE = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic                   write_q, write_d;
    logic                   size_q, size_d;
    logic                   signed_q, signed_d;
    logic                   byte_sel_q, byte_sel_d;
    logic [BYTE_ADDR_W-2:0] word_addr_q, word_addr_d;
    logic [15:0]            wdata_q, wdata_d;
    logic [15:0]            merge_q, merge_d;
    logic [15:0]            resp_data_q, resp_data_d;
    logic                   resp_err_q, resp_err_d;

    logic                   req_ready_c;
    logic [7:0]             rd_byte;
    logic [15:0]            load_ext;

    // Selected byte of the word being read, then extended for the load result.
    assign rd_byte  = byte_sel_q ? mem_read_data[15:8] : mem_read_data[7:0];
    assign load_ext = size_q   ? mem_read_data :
                      signed_q ? {{8{rd_byte[7]}}, rd_byte} :
                                 {8'h00, rd_byte};

    always_comb begin
        state_d          = state_q;
        write_d          = write_q;
        size_d           = size_q;
        signed_d         = signed_q;
        byte_sel_d       = byte_sel_q;
        word_addr_d      = word_addr_q;
        wdata_d          = wdata_q;
        merge_d          = merge_q;
        resp_data_d      = resp_data_q;
        resp_err_d       = resp_err_q;
        req_ready_c      = 1'b0;
        mem_read_enable  = 1'b0;
        mem_write_enable = 1'b0;
        mem_write_data   = 16'h0000;

        case (state_q)
            ST_IDLE: begin
                req_ready_c = 1'b1;
                if (bus.req_valid) begin
                    write_d     = bus.req_write;
                    size_d      = bus.req_size;
                    signed_d    = bus.req_signed;
                    byte_sel_d  = bus.req_addr[0];
                    word_addr_d = bus.req_addr[BYTE_ADDR_W-1:1];
                    wdata_d     = bus.req_wdata;
                    resp_data_d = 16'h0000;
                    resp_err_d  = 1'b0;
                    state_d     = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (size_q && byte_sel_q) begin
                    resp_err_d  = 1'b1;
                    resp_data_d = 16'h0000;
                    state_d     = ST_RESP;
                end else if (write_q && size_q) begin
                    mem_write_enable = 1'b1;
                    mem_write_data   = wdata_q;
                    state_d          = ST_RESP;
                end else if (!write_q) begin
                    mem_read_enable = 1'b1;
                    resp_data_d     = load_ext;
                    state_d         = ST_RESP;
                end else begin
                    mem_read_enable = 1'b1;
                    merge_d         = mem_read_data;
                    state_d         = ST_MERGE;
                end
            end
            ST_MERGE: begin
                mem_write_enable = 1'b1;
                mem_write_data   = byte_sel_q ? {wdata_q[7:0], merge_q[7:0]}
                                              : {merge_q[15:8], wdata_q[7:0]};
                state_d          = ST_RESP;
            end
            ST_RESP: begin
                if (bus.resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A cycle with reset high must never touch memory or accept work.
        if (reset) begin
            req_ready_c      = 1'b0;
            mem_read_enable  = 1'b0;
            mem_write_enable = 1'b0;
            mem_write_data   = 16'h0000;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            write_q     <= 1'b0;
            size_q      <= 1'b0;
            signed_q    <= 1'b0;
            byte_sel_q  <= 1'b0;
            word_addr_q <= '0;
            wdata_q     <= 16'h0000;
            merge_q     <= 16'h0000;
            resp_data_q <= 16'h0000;
            resp_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            write_q     <= write_d;
            size_q      <= size_d;
            signed_q    <= signed_d;
            byte_sel_q  <= byte_sel_d;
            word_addr_q <= word_addr_d;
            wdata_q     <= wdata_d;
            merge_q     <= merge_d;
            resp_data_q <= resp_data_d;
            resp_err_q  <= resp_err_d;
        end
    end

    assign mem_address    = 16'(word_addr_q);
    assign bus.req_ready  = req_ready_c;
    assign bus.resp_valid = (state_q == ST_RESP);
    assign bus.resp_data  = (state_q == ST_RESP) ? resp_data_q : 16'h0000;
    assign bus.resp_err   = (state_q == ST_RESP) ? resp_err_q : 1'b0;
endmodule

// File: tb/tb_lsu_mem_stage.sv
// Randomized self-checking bench for lsu_mem_stage against a word-array
// reference model of the data memory and the expected load results.
module tb_lsu_mem_stage;
    logic        clk;
    logic        reset;
    logic [15:0] mem_address;
    logic        mem_write_enable;
    logic        mem_read_enable;
    logic [15:0] mem_write_data;
    logic [15:0] mem_read_data;

    lsu_mem_stage_if #(.BYTE_ADDR_W(17)) bus ();

    lsu_mem_stage #(.BYTE_ADDR_W(17)) dut (
        .clk              (clk),
        .reset            (reset),
        .bus              (bus),
        .mem_address      (mem_address),
        .mem_write_enable (mem_write_enable),
        .mem_read_enable  (mem_read_enable),
        .mem_write_data   (mem_write_data),
        .mem_read_data    (mem_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory seen by the DUT: combinational read, write on the clock edge.
    logic [15:0] dmem [0:65535];
    logic        init_en;
    logic [15:0] init_addr;
    logic [15:0] init_data;
    assign mem_read_data = dmem[mem_address];
    always @(posedge clk) begin
        if (init_en) dmem[init_addr] <= init_data;
        else if (mem_write_enable) dmem[mem_address] <= mem_write_data;
    end

    // Strobe monitor: running totals, sampled away from the active edge.
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    int          viol_cnt = 0;
    logic [15:0] last_wr_addr = 16'h0;
    logic [15:0] last_wr_data = 16'h0;
    always @(negedge clk) begin
        if (mem_read_enable) rd_cnt++;
        if (mem_write_enable) begin
            wr_cnt++;
            last_wr_addr = mem_address;
            last_wr_data = mem_write_data;
        end
        if (mem_read_enable && mem_write_enable) viol_cnt++;
        if (!mem_write_enable && mem_write_data != 16'h0) viol_cnt++;
    end

    logic [15:0] ref_mem [0:63];
    int n_tests = 0;
    int n_fail  = 0;
    int n_txn   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_txn(input logic wr, input logic sz, input logic sg,
                          input logic [16:0] addr, input logic [15:0] wd, input int hold);
        int          w, b, lat, rd0, wr0, v0, exp_rd, exp_wr;
        logic [15:0] old, exp_data, new_word;
        logic        exp_err;
        int          byte_v;
        logic [15:0] held_data;
        logic        held_err;

        w = int'(addr >> 1);
        b = int'(addr[0]);
        old = ref_mem[w];
        exp_err = 1'b0; exp_data = 16'h0; exp_rd = 0; exp_wr = 0; new_word = old;
        if (sz && b == 1) begin
            exp_err = 1'b1;
        end else if (wr && sz) begin
            new_word = wd; exp_wr = 1;
        end else if (wr) begin
            new_word = (old & ~(16'h00FF << (8 * b))) | ((wd & 16'h00FF) << (8 * b));
            exp_rd = 1; exp_wr = 1;
        end else begin
            exp_rd = 1;
            byte_v = int'((old >> (8 * b)) & 16'h00FF);
            if (sz)      exp_data = old;
            else if (sg) exp_data = 16'((byte_v ^ 128) - 128);
            else         exp_data = 16'(byte_v);
        end
        ref_mem[w] = new_word;

        @(negedge clk);
        check("req_ready_idle", 32'(bus.req_ready), 32'd1);
        rd0 = rd_cnt; wr0 = wr_cnt; v0 = viol_cnt;
        bus.req_valid  = 1'b1;
        bus.req_write  = wr;
        bus.req_size   = sz;
        bus.req_signed = sg;
        bus.req_addr   = addr;
        bus.req_wdata  = wd;
        @(posedge clk);
        #1;
        // Scramble the request fields so only the registered copy matters.
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'($urandom);
        bus.req_size   = 1'($urandom);
        bus.req_signed = 1'($urandom);
        bus.req_addr   = 17'($urandom);
        bus.req_wdata  = 16'($urandom);

        lat = 1;
        @(negedge clk);
        while (!bus.resp_valid && lat < 8) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check("latency", 32'(lat), (wr && !sz) ? 32'd3 : 32'd2);
        check("resp_err", 32'(bus.resp_err), 32'(exp_err));
        check("resp_data", 32'(bus.resp_data), 32'(exp_data));
        check("mem_address", 32'(mem_address), 32'(w));
        held_data = bus.resp_data;
        held_err  = bus.resp_err;

        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_valid", 32'(bus.resp_valid), 32'd1);
            check("hold_data", 32'(bus.resp_data), 32'(held_data));
            check("hold_err", 32'(bus.resp_err), 32'(held_err));
            check("hold_req_ready", 32'(bus.req_ready), 32'd0);
        end

        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.resp_ready = 1'b0;
        check("resp_valid_drop", 32'(bus.resp_valid), 32'd0);
        check("req_ready_back", 32'(bus.req_ready), 32'd1);
        check("rd_strobes", 32'(rd_cnt - rd0), 32'(exp_rd));
        check("wr_strobes", 32'(wr_cnt - wr0), 32'(exp_wr));
        check("strobe_rules", 32'(viol_cnt - v0), 32'd0);
        if (exp_wr == 1) begin
            check("wr_addr", 32'(last_wr_addr), 32'(w));
            check("wr_data", 32'(last_wr_data), 32'(new_word));
        end
        n_txn++;
        $display("[TB] txn %0d wr=%0d sz=%0d sg=%0d addr=0x%0h wd=0x%0h -> data=0x%0h err=%0d lat=%0d",
                 n_txn, wr, sz, sg, addr, wd, held_data, held_err, lat);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        init_en = 1'b0; init_addr = 16'h0; init_data = 16'h0;
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 1'b0;
        bus.req_signed = 1'b0; bus.req_addr = '0; bus.req_wdata = 16'h0;
        bus.resp_ready = 1'b0;

        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            init_en   = 1'b1;
            init_addr = 16'(i);
            init_data = 16'($urandom);
            ref_mem[i] = init_data;
        end
        @(negedge clk);
        init_en = 1'b0;
        @(negedge clk);

        check("rst_req_ready", 32'(bus.req_ready), 32'd0);
        check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst_resp_err", 32'(bus.resp_err), 32'd0);
        check("rst_resp_data", 32'(bus.resp_data), 32'd0);
        check("rst_mem_address", 32'(mem_address), 32'd0);
        check("rst_mem_we", 32'(mem_write_enable), 32'd0);
        check("rst_mem_re", 32'(mem_read_enable), 32'd0);
        check("rst_mem_wdata", 32'(mem_write_data), 32'd0);
        reset = 1'b0;

        // Directed scenarios.
        do_txn(1'b1, 1'b1, 1'b0, 17'h00010, 16'hBEEF, 0);
        do_txn(1'b0, 1'b1, 1'b0, 17'h00010, 16'h0000, 0);
        do_txn(1'b1, 1'b0, 1'b0, 17'h00011, 16'h005A, 0);
        check("merge_word", 32'(dmem[8]), 32'h5AEF);
        do_txn(1'b0, 1'b0, 1'b1, 17'h00011, 16'h0000, 0);
        do_txn(1'b0, 1'b0, 1'b1, 17'h00010, 16'h0000, 0);
        do_txn(1'b0, 1'b0, 1'b0, 17'h00010, 16'h0000, 0);
        do_txn(1'b0, 1'b1, 1'b0, 17'h00013, 16'h0000, 0);
        do_txn(1'b1, 1'b1, 1'b0, 17'h00013, 16'h1234, 0);
        do_txn(1'b0, 1'b1, 1'b0, 17'h00010, 16'h0000, 5);

        // Randomized traffic over a small address window to force reuse.
        for (int t = 0; t < 200; t++) begin
            do_txn(1'($urandom), 1'($urandom), 1'($urandom),
                   17'($urandom_range(0, 127)), 16'($urandom), int'($urandom_range(0, 3)));
        end

        // Reset in MERGE of a byte store: write suppressed, no response.
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_size = 1'b0;
        bus.req_signed = 1'b0; bus.req_addr = 17'h00021; bus.req_wdata = 16'h0077;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("merge_reached", 32'(mem_write_enable), 32'd1);
        reset = 1'b1;
        #1;
        check("merge_we_gated", 32'(mem_write_enable), 32'd0);
        @(posedge clk);
        #1;
        check("mrst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("mrst_mem_re", 32'(mem_read_enable), 32'd0);
        check("mrst_mem_address", 32'(mem_address), 32'd0);
        check("mrst_req_ready", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("mrst_req_ready_after", 32'(bus.req_ready), 32'd1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("mrst_no_resp", 32'(bus.resp_valid), 32'd0);
        end
        check("mrst_mem_intact", 32'(dmem[16]), 32'(ref_mem[16]));
        do_txn(1'b0, 1'b1, 1'b0, 17'h00020, 16'h0000, 1);

        for (int i = 0; i < 64; i++) begin
            check($sformatf("final_mem[%0d]", i), 32'(dmem[i]), 32'(ref_mem[i]));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
